// File: rtl/phase_accum.sv
// rtl/phase_accum.sv - two-phase operand capture and saturating accumulator
module phase_accum #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 24,
  parameter int LEN_W  = 8
) (
  input  logic              clk_i,
  input  logic              clear_i,
  input  logic              phi1_i,
  input  logic              phi2_i,
  input  logic              start_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_a_i,
  input  logic [DATA_W-1:0] in_b_i,
  output logic [ACC_W-1:0]  acc_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              sat_o,
  output logic              busy_o,
  output logic [1:0]        ssp_intr_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_P1 = 2'd1,
    OPND    = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  op_a_q, op_b_q;
  logic [LEN_W-1:0]   remaining_q;
  logic [ACC_W-1:0]   acc_q;
  logic               sat_q;
  logic               done_pulse_q;

  // Exact adder; the sum path is isolated so approximate variants can replace it.
  logic [DATA_W:0]    op_sum;
  logic [ACC_W:0]     acc_sum;
  logic               acc_ovf;

  logic start_ok;
  logic capture;
  logic commit;
  logic last_op;

  assign op_sum  = {1'b0, op_a_q} + {1'b0, op_b_q};
  assign acc_sum = {1'b0, acc_q} + {{(ACC_W - DATA_W){1'b0}}, op_sum};
  assign acc_ovf = acc_sum[ACC_W];

  assign start_ok = (state_q == IDLE) && start_i;
  assign capture  = (state_q == WAIT_P1) && phi1_i && in_valid_i;
  assign commit   = (state_q == OPND) && phi2_i;
  assign last_op  = (remaining_q == LEN_W'(1));

  // State register; clear_i drops the FSM to IDLE from anywhere, even mid-run.
  always_ff @(posedge clk_i or negedge clear_i) begin
    if (!clear_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and handshake outputs; each phase event advances the state, so held levels act once.
  always_comb begin
    state_d     = state_q;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    busy_o      = (state_q != IDLE);
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = (len_i == '0) ? DONE : WAIT_P1;
        end
      end
      WAIT_P1: begin
        in_ready_o = phi1_i;
        if (phi1_i && in_valid_i) begin
          state_d = OPND;
        end
      end
      OPND: begin
        if (phi2_i) begin
          state_d = last_op ? DONE : WAIT_P1;
        end
      end
      DONE: begin
        out_valid_o = 1'b1;
        if (out_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand capture on phi1, length bookkeeping on phi2.
  always_ff @(posedge clk_i or negedge clear_i) begin
    if (!clear_i) begin
      op_a_q      <= '0;
      op_b_q      <= '0;
      remaining_q <= '0;
    end else begin
      if (start_ok) begin
        remaining_q <= len_i;
      end else if (commit) begin
        remaining_q <= remaining_q - LEN_W'(1);
      end
      if (capture) begin
        op_a_q <= in_a_i;
        op_b_q <= in_b_i;
      end
    end
  end

  // Saturating accumulate; result and sticky flag persist until the next start.
  always_ff @(posedge clk_i or negedge clear_i) begin
    if (!clear_i) begin
      acc_q <= '0;
      sat_q <= 1'b0;
    end else if (start_ok) begin
      acc_q <= '0;
      sat_q <= 1'b0;
    end else if (commit) begin
      if (acc_ovf) begin
        acc_q <= '1;
        sat_q <= 1'b1;
      end else begin
        acc_q <= acc_sum[ACC_W-1:0];
      end
    end
  end

  // Done interrupt is high only on the cycle the FSM first lands in DONE.
  always_ff @(posedge clk_i or negedge clear_i) begin
    if (!clear_i) begin
      done_pulse_q <= 1'b0;
    end else begin
      done_pulse_q <= (state_d == DONE) && (state_q != DONE);
    end
  end

  assign acc_o      = acc_q;
  assign sat_o      = sat_q;
  assign ssp_intr_o = {out_valid_o & ~out_ready_i, done_pulse_q};

endmodule

// File: tb/tb_phase_accum.sv
// tb/tb_phase_accum.sv - directed self-checking bench for phase_accum
module tb_phase_accum;

  logic        clk_i = 1'b0;
  logic        clear_i;
  logic        phi1_i, phi2_i;
  logic        start_i;
  logic [7:0]  len_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [15:0] in_a_i, in_b_i;
  logic [23:0] acc_o;
  logic        out_valid_o;
  logic        out_ready_i;
  logic        sat_o;
  logic        busy_o;
  logic [1:0]  ssp_intr_o;

  int total = 0;
  int bad   = 0;

  phase_accum dut (
    .clk_i       (clk_i),
    .clear_i     (clear_i),
    .phi1_i      (phi1_i),
    .phi2_i      (phi2_i),
    .start_i     (start_i),
    .len_i       (len_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_a_i      (in_a_i),
    .in_b_i      (in_b_i),
    .acc_o       (acc_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .sat_o       (sat_o),
    .busy_o      (busy_o),
    .ssp_intr_o  (ssp_intr_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic start_run(input logic [7:0] n);
    start_i = 1'b1;
    len_i   = n;
    tick();
    start_i = 1'b0;
  endtask

  task automatic do_op(input logic [15:0] a, input logic [15:0] b);
    in_a_i = a; in_b_i = b; in_valid_i = 1'b1; phi1_i = 1'b1;
    #1 chk("in_ready_phi1", in_ready_o, 1);
    tick();
    phi1_i = 1'b0; in_valid_i = 1'b0; phi2_i = 1'b1;
    #1 chk("in_ready_opnd", in_ready_o, 0);
    tick();
    phi2_i = 1'b0;
  endtask

  initial begin
    clear_i = 1'b0; phi1_i = 0; phi2_i = 0; start_i = 0; len_i = 0;
    in_valid_i = 0; in_a_i = 0; in_b_i = 0; out_ready_i = 1'b1;
    tick();
    chk("rst_outs", {acc_o, sat_o, out_valid_o, busy_o, ssp_intr_o, in_ready_o}, 0);
    clear_i = 1'b1;
    tick();

    // Basic run, with a stray start while busy.
    start_run(3);
    chk("busy_run", busy_o, 1);
    do_op(1, 2);
    start_i = 1'b1; len_i = 8'd5;
    tick();
    start_i = 1'b0;
    do_op(3, 4);
    do_op(5, 6);
    chk("basic_valid", out_valid_o, 1);
    chk("basic_acc", acc_o, 21);
    chk("basic_sat", sat_o, 0);
    chk("basic_intr", ssp_intr_o, 2'b01);
    tick();
    chk("basic_idle", {out_valid_o, busy_o, ssp_intr_o}, 0);
    chk("basic_hold", acc_o, 21);

    // Back-pressure in DONE.
    start_run(3);
    do_op(1, 2);
    do_op(3, 4);
    out_ready_i = 1'b0;
    do_op(5, 6);
    chk("bp_pulse", ssp_intr_o, 2'b11);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) chk("bp_intr", ssp_intr_o, 2'b10);
      chk("bp_acc", acc_o, 21);
      tick();
    end
    out_ready_i = 1'b1;
    #1 chk("bp_release_intr", ssp_intr_o, 0);
    tick();
    chk("bp_idle", {out_valid_o, busy_o, ssp_intr_o}, 0);
    chk("bp_acc_kept", acc_o, 21);

    // Bubble: second phi1 window has no valid data; a stray phi2 must not accumulate.
    start_run(3);
    do_op(1, 2);
    phi1_i = 1'b1; in_valid_i = 1'b0; in_a_i = 16'd99; in_b_i = 16'd99;
    tick();
    phi1_i = 1'b0; phi2_i = 1'b1;
    tick();
    phi2_i = 1'b0;
    chk("bubble_acc_mid", acc_o, 3);
    do_op(3, 4);
    do_op(5, 6);
    chk("bubble_acc", acc_o, 21);
    chk("bubble_valid", out_valid_o, 1);
    tick();

    // Saturation then recovery.
    start_run(200);
    for (int i = 0; i < 200; i++) do_op(16'hFFFF, 16'hFFFF);
    chk("sat_acc", acc_o, 24'hFFFFFF);
    chk("sat_flag", sat_o, 1);
    chk("sat_valid", out_valid_o, 1);
    tick();
    start_run(1);
    chk("sat_cleared", {acc_o, sat_o}, 0);
    do_op(1, 1);
    chk("post_sat_acc", acc_o, 2);
    chk("post_sat_flag", sat_o, 0);
    tick();

    // Zero length.
    start_run(0);
    chk("zero_valid", out_valid_o, 1);
    chk("zero_acc", acc_o, 0);
    chk("zero_intr", ssp_intr_o, 2'b01);
    tick();
    chk("zero_idle", busy_o, 0);

    // Frozen phases: phi1 held 5 cycles, phi2 held 3 cycles.
    start_run(1);
    in_a_i = 16'd3; in_b_i = 16'd4; in_valid_i = 1'b1; phi1_i = 1'b1;
    tick();
    in_a_i = 16'd100;
    for (int i = 0; i < 4; i++) tick();
    chk("frz_ready", in_ready_o, 0);
    phi1_i = 1'b0; in_valid_i = 1'b0; phi2_i = 1'b1; out_ready_i = 1'b0;
    tick();
    chk("frz_pulse", ssp_intr_o, 2'b11);
    tick();
    tick();
    chk("frz_intr", ssp_intr_o, 2'b10);
    chk("frz_acc", acc_o, 7);
    phi2_i = 1'b0; out_ready_i = 1'b1;
    tick();

    // Asynchronous clear in OPND, then a clean run.
    start_run(2);
    phi1_i = 1'b1; in_valid_i = 1'b1; in_a_i = 16'd50; in_b_i = 16'd50;
    tick();
    phi1_i = 1'b0; in_valid_i = 1'b0; phi2_i = 1'b1;
    #2 clear_i = 1'b0;
    #1 chk("clr_outs", {acc_o, sat_o, out_valid_o, busy_o, ssp_intr_o, in_ready_o}, 0);
    phi2_i = 1'b0;
    tick();
    clear_i = 1'b1;
    tick();
    start_run(2);
    do_op(7, 8);
    do_op(9, 10);
    chk("clr_run_acc", acc_o, 34);
    chk("clr_run_valid", out_valid_o, 1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end

endmodule

// File: doc/phase_accum.md
Name: phase_accum

Overview:
- Downstream consumer of the two-phase clock unit.
- Uses phi1 to capture an operand pair and phi2 to commit the operand sum into a saturating accumulator.
- Runs for a programmed number of operations, then presents the result on a valid/ready port.
- Drives the 2-bit ssp_intr bus back to the clock unit: bit 1 freezes the phases under output back-pressure; bit 0 pulses on done.
- Adder kept exact here; approximate-adder variants drop into the sum path later.

Parameters:
- DATA_W, 16, operand width.
- ACC_W, 24, accumulator width; must be ≥ DATA_W+1.
- LEN_W, 8, width of the operation count.

Ports:
- clk_i  in  1  system clock, same clock that feeds the clock unit.
- clear_i  in  1  asynchronous active-low reset.
- phi1_i  in  1  phase-1 from clock unit; operand capture window.
- phi2_i  in  1  phase-2 from clock unit; accumulate window.
- start_i  in  1  begin a run; honoured in IDLE only.
- len_i  in  LEN_W  number of operand pairs; sampled on accepted start.
- in_valid_i  in  1  operand pair valid.
- in_ready_o  out  1  operand pair accepted when in_valid_i & in_ready_o.
- in_a_i  in  DATA_W  operand A, unsigned.
- in_b_i  in  DATA_W  operand B, unsigned.
- acc_o  out  ACC_W  accumulated result; stable while out_valid_o.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  downstream accepts result.
- sat_o  out  1  saturation occurred this run.
- busy_o  out  1  run in progress (state ≠ IDLE).
- ssp_intr_o  out  2  [1] phase freeze request, [0] done pulse.

Behaviour:
- Reset (clear_i low, asynchronous, any state incl. mid-run): state=IDLE; all outputs 0; internal op_a, op_b, remaining cleared.
- All flops are clocked on posedge clk_i.
- States: IDLE, WAIT_P1, OPND, DONE.
- IDLE:
  - in_ready_o=0.
  - start_i with len_i≠0: acc←0, sat←0, remaining←len_i, go to WAIT_P1.
  - start_i with len_i=0: acc←0, sat←0, go to DONE.
- WAIT_P1:
  - in_ready_o = phi1_i (combinational).
  - On phi1_i & in_valid_i: register in_a_i/in_b_i, go to OPND.
  - phi1_i high with in_valid_i low: no capture; stay, wait for next phi1 window.
- OPND:
  - in_ready_o=0.
  - On phi2_i: sum = op_a + op_b (DATA_W+1 bits, zero-extended to ACC_W+1).
  - acc ← min(acc + sum, 2^ACC_W−1); if clamped, sat←1.
  - remaining←remaining−1; next state DONE if remaining==1, else WAIT_P1.
- Each capture moves the FSM to the next state, so a phase level held over several cycles (clock unit frozen) never double-captures or double-accumulates.
- phi1_i & phi2_i both high (illegal from the clock unit): only the input relevant to the current state is used.
- DONE:
  - out_valid_o=1; acc_o, sat_o held.
  - ssp_intr_o[0]=1 for exactly the first DONE cycle.
  - ssp_intr_o[1] = out_valid_o & ~out_ready_i, combinational.
  - out_valid_o & out_ready_i: go to IDLE next cycle; acc_o and sat_o keep their value until the next start.
- Latency: phi2 cycle of the last op → out_valid_o high the next cycle.
- start_i outside IDLE is ignored.
- busy_o=1 in WAIT_P1, OPND and DONE.

Test Plan:
- Reset: assert clear_i mid-run in OPND → same cycle all outputs 0, state IDLE; after release, start_i len=2 runs cleanly.
- Basic: len=3, pairs (1,2),(3,4),(5,6), phases generated by clock unit → acc_o=21; out_valid_o one clk after third phi2; ssp_intr_o[0] high exactly one cycle; sat_o=0.
- Back-pressure: as basic, hold out_ready_i low 10 cycles in DONE → ssp_intr_o[1] high those 10 cycles, acc_o=21 stable; out_ready_i high → IDLE next cycle, ssp_intr_o=0.
- Bubble: drop in_valid_i during the 2nd phi1 window → no capture; pair taken at the following phi1; final acc_o=21, same as basic.
- Saturation: len=200, every pair (0xFFFF,0xFFFF) → acc_o=0xFFFFFF, sat_o=1; next run len=1 (1,1) → acc_o=2, sat_o=0.
- Zero length / frozen phases: start_i len=0 → DONE next cycle, acc_o=0, ssp_intr_o[0] pulse. Hold phi1_i high 5 cycles with in_valid_i high → exactly one capture.
